// File: rtl/nand_async_pkg.sv
// Shared definitions for the asynchronous NAND command/address/data sequencer.
// Holds the op encoding, the FSM state encoding and the phase counter width.
package nand_async_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_ADDR  = 2'd1,
    OP_WRITE = 2'd2,
    OP_READ  = 2'd3
  } nand_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } nand_state_e;

  // A phase lasting N cycles is entered with the counter at N-1 and left when it reads zero.
  function automatic logic [CNT_W-1:0] cnt_reload(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/nand_async_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags the final cycle of a phase.
module nand_async_timer
  import nand_async_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nand_async.sv
// Single-beat asynchronous NAND bus sequencer: SETUP -> PULSE -> HOLD -> DONE per request.
// Every PHY-facing output is a flop loaded from the next-state decode.
module nand_async_seq
  import nand_async_pkg::*;
#(
  parameter int T_SETUP  = 2,
  parameter int T_WP     = 3,
  parameter int T_WH     = 2,
  parameter int DQ_WIDTH = 8
) (
  input  logic                v_clk0,
  input  logic                v_rst0,
  // Request: accepted on a rising edge where req_valid && req_ready; req_ready is high only in IDLE.
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [DQ_WIDTH-1:0] req_data,
  input  logic                req_ce_sel,
  input  logic                cfg_wp_n,
  output logic                rsp_valid,
  output logic [DQ_WIDTH-1:0] rsp_data,
  output logic                v_ctrl_cle,
  output logic                v_ctrl_ale,
  output logic                v_ctrl_wrn,
  output logic                v_ctrl_wpn,
  output logic [1:0]          v_ctrl_cen,
  output logic                v_ctrl_wen,
  output logic                v_ctrl_wen_sel,
  output logic                v_dq_oe_n,
  output logic [DQ_WIDTH-1:0] v_wr_data_rise,
  output logic [DQ_WIDTH-1:0] v_wr_data_fall,
  input  logic [DQ_WIDTH-1:0] v_rd_data_comb,
  output logic [2:0]          dbg_state
);

  if (T_SETUP < 1 || T_SETUP > 15 || T_WP < 1 || T_WP > 15 || T_WH < 1 || T_WH > 15) begin : g_bad_timing
    $fatal(1, "nand_async_seq: T_SETUP/T_WP/T_WH must each be in 1..15");
  end

  localparam logic [CNT_W-1:0] LD_SETUP = cnt_reload(T_SETUP);
  localparam logic [CNT_W-1:0] LD_WP    = cnt_reload(T_WP);
  localparam logic [CNT_W-1:0] LD_WH    = cnt_reload(T_WH);

  nand_state_e         state_q, state_d;
  nand_op_e            op_q, op_d;
  logic [DQ_WIDTH-1:0] data_q, data_d;
  logic                ce_q, ce_d;

  logic                ready_q, ready_d;
  logic                cle_q, cle_d;
  logic                ale_q, ale_d;
  logic                wen_q, wen_d;
  logic                wrn_q, wrn_d;
  logic                wen_sel_q;
  logic                wpn_q;
  logic                oe_n_q, oe_n_d;
  logic [1:0]          cen_q, cen_d;
  logic [DQ_WIDTH-1:0] wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DQ_WIDTH-1:0] rsp_data_q;

  logic                accept;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_load_val;
  logic                tmr_zero;
  logic                rd_capture;
  logic                active;
  logic                drive_dq;

  nand_async_timer u_timer (
    .clk_i      (v_clk0),
    .rst_i      (v_rst0),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  assign accept     = (state_q == ST_IDLE) && ready_q && req_valid;
  assign rd_capture = (state_q == ST_PULSE) && tmr_zero && (op_q == OP_READ);

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d      = ST_PULSE;
          tmr_load     = 1'b1;
          tmr_load_val = LD_WP;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_d      = ST_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = LD_WH;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured only at acceptance and held for the whole transfer.
  always_comb begin
    op_d   = op_q;
    data_d = data_q;
    ce_d   = ce_q;
    if (accept) begin
      op_d   = nand_op_e'(req_op);
      data_d = req_data;
      ce_d   = req_ce_sel;
    end
  end

  always_comb begin
    active      = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
    drive_dq    = active && (op_d != OP_READ);
    cen_d       = 2'b11;
    if (active) begin
      cen_d[ce_d] = 1'b0;
    end
    cle_d       = active && (op_d == OP_CMD);
    ale_d       = active && (op_d == OP_ADDR);
    oe_n_d      = !drive_dq;
    wdata_d     = drive_dq ? data_d : '0;
    wen_d       = !((state_d == ST_PULSE) && (op_d != OP_READ));
    wrn_d       = !((state_d == ST_PULSE) && (op_d == OP_READ));
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE) && (op_d == OP_READ);
  end

  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_CMD;
      data_q      <= '0;
      ce_q        <= 1'b0;
      ready_q     <= 1'b0;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      wen_q       <= 1'b1;
      wrn_q       <= 1'b1;
      wen_sel_q   <= 1'b1;
      wpn_q       <= 1'b0;
      oe_n_q      <= 1'b1;
      cen_q       <= 2'b11;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      ce_q        <= ce_d;
      ready_q     <= ready_d;
      cle_q       <= cle_d;
      ale_q       <= ale_d;
      wen_q       <= wen_d;
      wrn_q       <= wrn_d;
      wen_sel_q   <= 1'b1;
      wpn_q       <= cfg_wp_n;
      oe_n_q      <= oe_n_d;
      cen_q       <= cen_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      if (rd_capture) begin
        rsp_data_q <= v_rd_data_comb;
      end
    end
  end

  assign req_ready      = ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign v_ctrl_cle     = cle_q;
  assign v_ctrl_ale     = ale_q;
  assign v_ctrl_wrn     = wrn_q;
  assign v_ctrl_wpn     = wpn_q;
  assign v_ctrl_cen     = cen_q;
  assign v_ctrl_wen     = wen_q;
  assign v_ctrl_wen_sel = wen_sel_q;
  assign v_dq_oe_n      = oe_n_q;
  assign v_wr_data_rise = wdata_q;
  assign v_wr_data_fall = wdata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_nand_async_seq.sv
// Directed bench for nand_async_seq: default-timing instance plus a 1/1/1 timing instance.
module tb_nand_async_seq;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'd0;
  logic [DW-1:0] req_data = '0;
  logic          req_ce_sel = 1'b0;
  logic          cfg_wp_n = 1'b0;
  logic [DW-1:0] rd_data = 8'h3C;

  logic          req_ready, rsp_valid, cle, ale, wrn, wpn, wen, wen_sel, oe_n;
  logic [DW-1:0] rsp_data, wd_rise, wd_fall;
  logic [1:0]    cen;
  logic [2:0]    st;

  logic          f_ready, f_rsp_valid, f_cle, f_ale, f_wrn, f_wpn, f_wen, f_wen_sel, f_oe_n;
  logic [DW-1:0] f_rsp_data, f_wd_rise, f_wd_fall;
  logic [1:0]    f_cen;
  logic [2:0]    f_st;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]    b2b_op[7]   = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
  logic [DW-1:0] b2b_dat[7]  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h30};
  logic [2:0]    f_st_exp[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic          f_wen_exp[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic          f_oe_exp[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  nand_async_seq dut (
    .v_clk0(clk), .v_rst0(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .req_ce_sel(req_ce_sel), .cfg_wp_n(cfg_wp_n),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .v_ctrl_cle(cle), .v_ctrl_ale(ale),
    .v_ctrl_wrn(wrn), .v_ctrl_wpn(wpn), .v_ctrl_cen(cen), .v_ctrl_wen(wen),
    .v_ctrl_wen_sel(wen_sel), .v_dq_oe_n(oe_n), .v_wr_data_rise(wd_rise),
    .v_wr_data_fall(wd_fall), .v_rd_data_comb(rd_data), .dbg_state(st)
  );

  nand_async_seq #(.T_SETUP(1), .T_WP(1), .T_WH(1), .DQ_WIDTH(DW)) dut_f (
    .v_clk0(clk), .v_rst0(rst), .req_valid(req_valid), .req_ready(f_ready),
    .req_op(req_op), .req_data(req_data), .req_ce_sel(req_ce_sel), .cfg_wp_n(cfg_wp_n),
    .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data), .v_ctrl_cle(f_cle), .v_ctrl_ale(f_ale),
    .v_ctrl_wrn(f_wrn), .v_ctrl_wpn(f_wpn), .v_ctrl_cen(f_cen), .v_ctrl_wen(f_wen),
    .v_ctrl_wen_sel(f_wen_sel), .v_dq_oe_n(f_oe_n), .v_wr_data_rise(f_wd_rise),
    .v_wr_data_fall(f_wd_fall), .v_rd_data_comb(rd_data), .dbg_state(f_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_wp_n = 1'b1; req_valid = 1'b0;
    tick(); tick();
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", req_ready); end
    n_tests++; if (cen !== 2'b11) begin n_fail++; $display("FAIL rst_cen got %b want 11", cen); end
    n_tests++; if (cle !== 1'b0 || ale !== 1'b0) begin n_fail++; $display("FAIL rst_cle_ale got %b%b want 00", cle, ale); end
    n_tests++; if (wen !== 1'b1 || wrn !== 1'b1) begin n_fail++; $display("FAIL rst_wen_wrn got %b%b want 11", wen, wrn); end
    n_tests++; if (wen_sel !== 1'b1) begin n_fail++; $display("FAIL rst_wen_sel got %b want 1", wen_sel); end
    n_tests++; if (wpn !== 1'b0) begin n_fail++; $display("FAIL rst_wpn got %b want 0", wpn); end
    n_tests++; if (oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n got %b want 1", oe_n); end
    n_tests++; if (wd_rise !== 8'h00 || wd_fall !== 8'h00) begin n_fail++; $display("FAIL rst_wdata got %h/%h want 00", wd_rise, wd_fall); end
    n_tests++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp got %b/%h want 0/00", rsp_valid, rsp_data); end
    n_tests++; if (st !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", st); end
    rst = 1'b0;
    tick();
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise got %b want 1", req_ready); end
    n_tests++; if (wpn !== 1'b1) begin n_fail++; $display("FAIL wpn_follow got %b want 1", wpn); end
    n_tests++; if (wen_sel !== 1'b1) begin n_fail++; $display("FAIL run_wen_sel got %b want 1", wen_sel); end
  endtask

  task automatic test_cmd();
    bit ok;
    int cle_n = 0, wen_n = 0, wen_first = -1, cen_n = 0, dq_n = 0, wrn_n = 0, rsp_n = 0, ready_k = -1;
    wait_ready(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cmd_wait_ready got timeout want ready"); end
    req_valid = 1'b1; req_op = 2'd0; req_data = 8'h70; req_ce_sel = 1'b0;
    tick();
    req_valid = 1'b0; req_data = 8'hFF; req_ce_sel = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (cle) cle_n++;
      if (!wen) begin wen_n++; if (wen_first < 0) wen_first = k; end
      if (cen == 2'b10) cen_n++;
      if (!oe_n && wd_rise == 8'h70 && wd_fall == 8'h70) dq_n++;
      if (!wrn) wrn_n++;
      if (rsp_valid) rsp_n++;
      if (req_ready && ready_k < 0) ready_k = k;
      tick();
    end
    n_tests++; if (cle_n != 7) begin n_fail++; $display("FAIL cmd_cle_cycles got %0d want 7", cle_n); end
    n_tests++; if (wen_n != 3) begin n_fail++; $display("FAIL cmd_wen_cycles got %0d want 3", wen_n); end
    n_tests++; if (wen_first != 2) begin n_fail++; $display("FAIL cmd_wen_start got %0d want 2", wen_first); end
    n_tests++; if (cen_n != 7) begin n_fail++; $display("FAIL cmd_cen10_cycles got %0d want 7", cen_n); end
    n_tests++; if (dq_n != 7) begin n_fail++; $display("FAIL cmd_dq70_cycles got %0d want 7", dq_n); end
    n_tests++; if (wrn_n != 0 || rsp_n != 0) begin n_fail++; $display("FAIL cmd_no_read got wrn %0d rsp %0d want 0 0", wrn_n, rsp_n); end
    // ready seen after edge 8 means the next accept lands on edge 9
    n_tests++; if (ready_k != 8) begin n_fail++; $display("FAIL cmd_ready_gap got %0d want 8", ready_k); end
  endtask

  task automatic test_read();
    bit ok;
    int wrn_n = 0, oe_n0 = 0, cen_n = 0, rsp_n = 0, rsp_k = -1, wen_n = 0, ready_k = -1;
    logic [DW-1:0] rsp_seen = '0;
    wait_ready(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL read_wait_ready got timeout want ready"); end
    req_valid = 1'b1; req_op = 2'd3; req_data = 8'h11; req_ce_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k == 4) rd_data = 8'hA5;
      else if (!wrn) rd_data = 8'h5A;
      else rd_data = 8'h3C;
      if (!wrn) wrn_n++;
      if (!oe_n) oe_n0++;
      if (!wen) wen_n++;
      if (cen == 2'b01) cen_n++;
      if (rsp_valid) begin rsp_n++; rsp_k = k; rsp_seen = rsp_data; end
      if (req_ready && ready_k < 0) ready_k = k;
      tick();
    end
    rd_data = 8'h3C;
    n_tests++; if (wrn_n != 3) begin n_fail++; $display("FAIL read_wrn_cycles got %0d want 3", wrn_n); end
    n_tests++; if (oe_n0 != 0) begin n_fail++; $display("FAIL read_oe_n got %0d low cycles want 0", oe_n0); end
    n_tests++; if (wen_n != 0) begin n_fail++; $display("FAIL read_wen got %0d low cycles want 0", wen_n); end
    n_tests++; if (cen_n != 7) begin n_fail++; $display("FAIL read_cen01_cycles got %0d want 7", cen_n); end
    n_tests++; if (rsp_n != 1 || rsp_k != 7) begin n_fail++; $display("FAIL read_rsp_valid got %0d pulses at %0d want 1 at 7", rsp_n, rsp_k); end
    n_tests++; if (rsp_seen !== 8'hA5) begin n_fail++; $display("FAIL read_rsp_data got %h want a5", rsp_seen); end
    n_tests++; if (rsp_data !== 8'hA5) begin n_fail++; $display("FAIL read_rsp_hold got %h want a5", rsp_data); end
    n_tests++; if (ready_k != 8) begin n_fail++; $display("FAIL read_ready_gap got %0d want 8", ready_k); end
  endtask

  task automatic test_back_to_back();
    bit ok, will_acc;
    int n_acc = 0, cur = -1, low_n = 0, overlap_n = 0, bad_ce_n = 0, ale_n = 0, cle_n = 0, dq_bad = 0, gap_bad = 0;
    int acc_cyc[7];
    wait_ready(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_wait_ready got timeout want ready"); end
    req_valid = 1'b1; req_ce_sel = 1'b0; req_op = b2b_op[0]; req_data = b2b_dat[0];
    for (int cyc = 0; cyc < 75; cyc++) begin
      if (cen != 2'b11) begin
        low_n++;
        if (req_ready) overlap_n++;
        if (cen != 2'b10) bad_ce_n++;
      end
      if (!oe_n && cur >= 0 && wd_rise !== b2b_dat[cur]) dq_bad++;
      if (ale) ale_n++;
      if (cle) cle_n++;
      will_acc = req_valid && req_ready;
      tick();
      if (will_acc && n_acc < 7) begin
        acc_cyc[n_acc] = cyc;
        cur = n_acc;
        n_acc++;
        if (n_acc < 7) begin req_op = b2b_op[n_acc]; req_data = b2b_dat[n_acc]; end
        else req_valid = 1'b0;
      end
    end
    for (int i = 1; i < n_acc; i++) if (acc_cyc[i] - acc_cyc[i-1] != 9) gap_bad++;
    n_tests++; if (n_acc != 7) begin n_fail++; $display("FAIL b2b_accepts got %0d want 7", n_acc); end
    n_tests++; if (gap_bad != 0) begin n_fail++; $display("FAIL b2b_gap got %0d gaps not 9 want 0", gap_bad); end
    n_tests++; if (low_n != 49 || bad_ce_n != 0) begin n_fail++; $display("FAIL b2b_ce_low got %0d cycles %0d wrong want 49 0", low_n, bad_ce_n); end
    n_tests++; if (overlap_n != 0) begin n_fail++; $display("FAIL b2b_overlap got %0d want 0", overlap_n); end
    n_tests++; if (ale_n != 35 || cle_n != 14) begin n_fail++; $display("FAIL b2b_ale_cle got %0d/%0d want 35/14", ale_n, cle_n); end
    n_tests++; if (dq_bad != 0) begin n_fail++; $display("FAIL b2b_dq got %0d bad cycles want 0", dq_bad); end
  endtask

  task automatic test_busy_toggle();
    bit ok;
    int extra = 0, dq_bad = 0, dq_ok = 0, cle_n = 0, wen_n = 0;
    wait_ready(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL busy_wait_ready got timeout want ready"); end
    req_valid = 1'b1; req_op = 2'd2; req_data = 8'h5A; req_ce_sel = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 7) ? k[0] : 1'b0;
      req_op = 2'd0; req_data = 8'hE7 + 8'(k); req_ce_sel = 1'b1;
      if (req_valid && req_ready) extra++;
      if (!oe_n) begin if (wd_rise !== 8'h5A || wd_fall !== 8'h5A) dq_bad++; else dq_ok++; end
      if (cle) cle_n++;
      if (!wen) wen_n++;
      tick();
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL busy_extra_accept got %0d want 0", extra); end
    n_tests++; if (dq_bad != 0 || dq_ok != 7) begin n_fail++; $display("FAIL busy_latched_data got bad %0d ok %0d want 0 7", dq_bad, dq_ok); end
    n_tests++; if (cle_n != 0 || wen_n != 3) begin n_fail++; $display("FAIL busy_strobes got cle %0d wen %0d want 0 3", cle_n, wen_n); end
  endtask

  task automatic test_reset_mid();
    bit ok, found = 1'b0;
    int rsp_n = 0, cen_n = 0;
    wait_ready(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_wait_ready got timeout want ready"); end
    req_valid = 1'b1; req_op = 2'd2; req_data = 8'hC3; req_ce_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!wen) begin found = 1'b1; break; end
      tick();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rmid_pulse got no wen low want wen low"); end
    rst = 1'b1;
    tick();
    n_tests++; if (wen !== 1'b1 || cen !== 2'b11 || oe_n !== 1'b1) begin n_fail++; $display("FAIL rmid_abort got wen %b cen %b oe_n %b want 1 11 1", wen, cen, oe_n); end
    n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || st !== 3'd0) begin n_fail++; $display("FAIL rmid_state got rsp %b rdy %b st %0d want 0 0 0", rsp_valid, req_ready, st); end
    rst = 1'b0;
    tick();
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", req_ready); end
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) rsp_n++;
      if (cen != 2'b11) cen_n++;
      tick();
    end
    n_tests++; if (rsp_n != 0 || cen_n != 0) begin n_fail++; $display("FAIL rmid_quiet got rsp %0d ce %0d want 0 0", rsp_n, cen_n); end
  endtask

  task automatic test_fast();
    int n_acc = 0, post = -1, st_bad = 0, wen_bad = 0, oe_bad = 0, gap_bad = 0, last_acc = -1;
    bit will_acc;
    rst = 1'b1; req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if (f_ready !== 1'b1) begin n_fail++; $display("FAIL fast_ready got %b want 1", f_ready); end
    req_valid = 1'b1; req_op = 2'd2; req_data = 8'h77; req_ce_sel = 1'b0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (post >= 0 && post < 5) begin
        if (f_st !== f_st_exp[post]) st_bad++;
        if (f_wen !== f_wen_exp[post]) wen_bad++;
        if (f_oe_n !== f_oe_exp[post]) oe_bad++;
      end
      will_acc = req_valid && f_ready;
      tick();
      if (post >= 0) post++;
      if (will_acc) begin
        if (last_acc >= 0 && cyc - last_acc != 5) gap_bad++;
        last_acc = cyc; n_acc++; post = 0;
      end
    end
    req_valid = 1'b0;
    n_tests++; if (n_acc != 3 || gap_bad != 0) begin n_fail++; $display("FAIL fast_period got %0d accepts %0d bad gaps want 3 0", n_acc, gap_bad); end
    n_tests++; if (st_bad != 0) begin n_fail++; $display("FAIL fast_phases got %0d bad cycles want 0", st_bad); end
    n_tests++; if (wen_bad != 0 || oe_bad != 0) begin n_fail++; $display("FAIL fast_strobes got wen %0d oe %0d bad want 0 0", wen_bad, oe_bad); end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_read();
    test_back_to_back();
    test_busy_toggle();
    test_reset_mid();
    test_fast();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nand_async_seq.md
NAND_ASYNC_SEQ -- requirements
Module: nand_async_seq

Interface
- REQ-001 SHALL have parameter T_SETUP, default 2, meaning cycles that CLE/ALE/DQ are set up before the strobe falls; legal range 1..15.
- REQ-002 SHALL have parameter T_WP, default 3, meaning cycles WE# or RE# is held low; legal range 1..15.
- REQ-003 SHALL have parameter T_WH, default 2, meaning cycles the strobe is high after the pulse; legal range 1..15.
- REQ-004 SHALL have parameter DQ_WIDTH, default 8, meaning data byte width.
- REQ-005 SHALL have port v_clk0, input, 1 bit: the single clock. All logic is on its rising edge.
- REQ-006 SHALL have port v_rst0, input, 1 bit: synchronous, active-high reset.
- REQ-007 SHALL have port req_valid, input, 1 bit: a request is offered.
- REQ-008 SHALL have port req_ready, output, 1 bit: a request is accepted when req_valid && req_ready.
- REQ-009 SHALL have port req_op, input, 2 bits: 0=CMD, 1=ADDR, 2=WRITE, 3=READ.
- REQ-010 SHALL have port req_data, input, DQ_WIDTH bits: the command, address or write byte.
- REQ-011 SHALL have port req_ce_sel, input, 1 bit: the target chip enable index.
- REQ-012 SHALL have port cfg_wp_n, input, 1 bit: write-protect level, passed to v_ctrl_wpn after one register stage.
- REQ-013 SHALL have ports rsp_valid (output, 1 bit) and rsp_data (output, DQ_WIDTH bits): the READ result.
- REQ-014 SHALL have the following PHY-facing outputs: v_ctrl_cle, v_ctrl_ale, v_ctrl_wrn (RE#), v_ctrl_wpn, v_ctrl_cen[1:0], v_ctrl_wen, v_ctrl_wen_sel, v_dq_oe_n, v_wr_data_rise[DQ_WIDTH], v_wr_data_fall[DQ_WIDTH].
- REQ-015 SHALL have PHY-facing input v_rd_data_comb, DQ_WIDTH bits.

Function
- REQ-016 SHALL implement the FSM states IDLE, SETUP, PULSE, HOLD and DONE. All outputs SHALL be registered.
- REQ-017 SHALL drive req_ready=1 only in IDLE. On acceptance it SHALL latch op, data and ce_sel, then go to SETUP.
- REQ-018 SHALL drive v_ctrl_cen[ce_sel]=0 from SETUP through HOLD. The other CE bit and every CE bit in IDLE/DONE SHALL be 1.
- REQ-019 SHALL assert v_ctrl_cle=1 for CMD only and v_ctrl_ale=1 for ADDR only, from SETUP through HOLD.
- REQ-020 SHALL, for CMD, ADDR and WRITE, drive v_dq_oe_n=0 and v_wr_data_rise=v_wr_data_fall=latched data from SETUP through HOLD. For READ, v_dq_oe_n SHALL stay 1.
- REQ-021 SHALL drive v_ctrl_wen=0 in PULSE for non-READ ops and 1 otherwise.
- REQ-022 SHALL drive v_ctrl_wrn=0 in PULSE for READ and 1 otherwise.
- REQ-023 SHALL hold v_ctrl_wen_sel=1 at all times (async WE# mode).
- REQ-024 SHALL stay in SETUP for T_SETUP cycles, PULSE for T_WP cycles and HOLD for T_WH cycles, using one 4-bit down-counter reloaded on each state entry.
- REQ-025 SHALL spend 1 cycle in DONE, then return to IDLE. Accept-to-next-ready SHALL be T_SETUP+T_WP+T_WH+2 cycles (9 with defaults).
- REQ-026 SHALL, for READ, capture v_rd_data_comb into rsp_data on the last PULSE cycle and pulse rsp_valid=1 for exactly one cycle in DONE.
- REQ-027 SHALL hold rsp_data stable until the next READ capture.
- REQ-028 SHALL ignore req_valid outside IDLE. Request inputs are sampled only at acceptance.
- REQ-029 SHALL fire an elaboration-time assertion if any timing parameter is 0 or greater than 15.

Reset
- REQ-030 SHALL, while v_rst0=1 on a clock edge, set: state IDLE, req_ready=0, v_ctrl_cen=2'b11, v_ctrl_cle=0, v_ctrl_ale=0, v_ctrl_wen=1, v_ctrl_wrn=1, v_ctrl_wen_sel=1, v_ctrl_wpn=0, v_dq_oe_n=1, write data=0, rsp_valid=0, rsp_data=0, counter=0.
- REQ-031 SHALL, on reset mid-operation, abort immediately with no rsp_valid. req_ready SHALL rise the first cycle after v_rst0 deasserts.

Structure
- REQ-032 SHALL put the op encoding, FSM state enum and counter width in shared package nand_async_pkg.
- REQ-033 SHALL use one sub-module, nand_async_timer (loadable 4-bit down-counter with a zero flag).

Verification
- REQ-034 SHALL cover: CMD 0x70 with ce_sel=0 -> cle=1 for 7 cycles, wen=0 for exactly 3 cycles, dq=0x70 with oe_n=0, cen=2'b10, ready again 9 cycles after accept.
- REQ-035 SHALL cover: READ with ce_sel=1 and v_rd_data_comb=0xA5 during PULSE -> wrn=0 for 3 cycles, oe_n stays 1, single rsp_valid with rsp_data=0xA5.
- REQ-036 SHALL cover: back-to-back CMD 0x00, five ADDR, CMD 0x30 with req_valid held high -> each op accepted 9 cycles apart, no overlap, CE held low only during each op.
- REQ-037 SHALL cover: v_rst0 pulsed during PULSE of a WRITE -> next cycle wen=1, cen=2'b11, oe_n=1, no rsp_valid.
- REQ-038 SHALL cover: req_valid toggled while busy -> no extra acceptance, latched data unchanged.
- REQ-039 SHALL cover: parameters T_SETUP=1, T_WP=1, T_WH=1 -> 5-cycle op period, each phase exactly 1 cycle.
